// File: rtl/bvh_traverse_ctrl.sv
// Stack-based BVH traversal controller feeding the combinational ray/box intersector.
// Walks one ray through node memory depth-first and emits a leaf record per box-hit leaf.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for a ray, ray_ready high
// S_FETCH | node read strobe issued for node_addr
// S_TEST  | node data valid, intersector result sampled
// S_LEAF  | leaf record held until downstream accepts it
// S_POP   | resume from stack top, or finish when stack empty
// S_DONE  | one-cycle trav_done pulse
module bvh_traverse_ctrl #(
    parameter int NODE_AW     = 10,
    parameter int PRIM_W      = 16,
    parameter int STACK_DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ray_valid,
    output logic               ray_ready,
    input  logic [71:0]        ray_orig_in,
    input  logic [71:0]        ray_inv_dir_in,
    input  logic [47:0]        ray_range_in,
    output logic               node_rd_en,
    output logic [NODE_AW-1:0] node_addr,
    input  logic [164:0]       node_data,
    output logic [71:0]        isect_orig,
    output logic [71:0]        isect_inv_dir,
    output logic [143:0]       isect_box,
    output logic [47:0]        isect_prev_range,
    input  logic               isect_hit,
    input  logic [47:0]        isect_range,
    output logic               leaf_valid,
    input  logic               leaf_ready,
    output logic [PRIM_W-1:0]  leaf_prim,
    output logic [47:0]        leaf_range,
    output logic               trav_done,
    output logic               stack_ovf
);
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = $clog2(STACK_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_TEST, S_LEAF, S_POP, S_DONE
    } state_t;

    state_t             state;
    logic [SP_W-1:0]    sp;
    logic [SP_W-1:0]    sp_m1;
    logic [IDX_W-1:0]   push_idx;
    logic [IDX_W-1:0]   pop_idx;
    logic [NODE_AW-1:0] stk_addr  [STACK_DEPTH];
    logic [47:0]        stk_range [STACK_DEPTH];
    logic [71:0]        orig_q;
    logic [71:0]        inv_q;
    logic [143:0]       box_q;
    logic [47:0]        cur_range;
    logic               is_leaf;
    logic               stack_full;
    logic               push_en;
    logic [NODE_AW-1:0] child0;
    logic [NODE_AW-1:0] child1;

    always_comb begin
        is_leaf    = node_data[144];
        child0     = NODE_AW'(node_data[154:145]);
        child1     = NODE_AW'(node_data[164:155]);
        stack_full = (sp == SP_W'(STACK_DEPTH));
        sp_m1      = sp - SP_W'(1);
        push_idx   = sp[IDX_W-1:0];
        pop_idx    = sp_m1[IDX_W-1:0];
        push_en    = (state == S_TEST) && isect_hit && !is_leaf && !stack_full;
    end

    // The box comes straight from node memory in TEST; elsewhere hold the last one to avoid toggling.
    assign isect_box        = (state == S_TEST) ? node_data[143:0] : box_q;
    assign isect_orig       = orig_q;
    assign isect_inv_dir    = inv_q;
    assign isect_prev_range = cur_range;

    always_ff @(posedge clk) begin
        if (push_en) begin
            stk_addr[push_idx]  <= child1;
            stk_range[push_idx] <= isect_range;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            sp         <= '0;
            ray_ready  <= 1'b1;
            node_rd_en <= 1'b0;
            node_addr  <= '0;
            orig_q     <= '0;
            inv_q      <= '0;
            box_q      <= '0;
            cur_range  <= '0;
            leaf_valid <= 1'b0;
            leaf_prim  <= '0;
            leaf_range <= '0;
            trav_done  <= 1'b0;
            stack_ovf  <= 1'b0;
        end else begin
            trav_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ray_valid && ray_ready) begin
                        orig_q     <= ray_orig_in;
                        inv_q      <= ray_inv_dir_in;
                        cur_range  <= ray_range_in;
                        node_addr  <= '0;
                        sp         <= '0;
                        stack_ovf  <= 1'b0;
                        ray_ready  <= 1'b0;
                        node_rd_en <= 1'b1;
                        state      <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    node_rd_en <= 1'b0;
                    state      <= S_TEST;
                end
                S_TEST: begin
                    box_q <= node_data[143:0];
                    if (!isect_hit) begin
                        state <= S_POP;
                    end else if (is_leaf) begin
                        leaf_valid <= 1'b1;
                        leaf_prim  <= PRIM_W'(node_data[154:145]);
                        leaf_range <= isect_range;
                        state      <= S_LEAF;
                    end else begin
                        // A full stack drops the far child; the near child is still walked.
                        if (stack_full) begin
                            stack_ovf <= 1'b1;
                        end else begin
                            sp <= sp + SP_W'(1);
                        end
                        node_addr  <= child0;
                        cur_range  <= isect_range;
                        node_rd_en <= 1'b1;
                        state      <= S_FETCH;
                    end
                end
                S_LEAF: begin
                    if (leaf_ready) begin
                        leaf_valid <= 1'b0;
                        state      <= S_POP;
                    end
                end
                S_POP: begin
                    if (sp == '0) begin
                        trav_done <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        sp         <= sp_m1;
                        node_addr  <= stk_addr[pop_idx];
                        cur_range  <= stk_range[pop_idx];
                        node_rd_en <= 1'b1;
                        state      <= S_FETCH;
                    end
                end
                S_DONE: begin
                    ray_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bvh_traverse_ctrl.sv
// Testbench for bvh_traverse_ctrl: node memory and intersector are table-driven models,
// expected traversal comes from a depth-first reference walk over the same tables.
module tb_bvh_traverse_ctrl;
    typedef struct packed {
        logic [9:0]  a;
        logic [47:0] r;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          ray_valid;
    logic          ray_ready;
    logic [71:0]   ray_orig_in;
    logic [71:0]   ray_inv_dir_in;
    logic [47:0]   ray_range_in;
    logic          node_rd_en;
    logic [9:0]    node_addr;
    logic [164:0]  node_data = '0;
    logic [71:0]   isect_orig;
    logic [71:0]   isect_inv_dir;
    logic [143:0]  isect_box;
    logic [47:0]   isect_prev_range;
    logic          isect_hit;
    logic [47:0]   isect_range;
    logic          leaf_valid;
    logic          leaf_ready;
    logic [15:0]   leaf_prim;
    logic [47:0]   leaf_range;
    logic          trav_done;
    logic          stack_ovf;

    logic [143:0]  box_tbl  [1024];
    logic          leaf_tbl [1024];
    logic          hit_tbl  [1024];
    logic [9:0]    c0_tbl   [1024];
    logic [9:0]    c1_tbl   [1024];
    logic [47:0]   rng_tbl  [1024];
    logic [9:0]    rd_addr_q = '0;

    int errors = 0;
    int checks = 0;

    logic [9:0]  got_addr[$];
    logic        got_ovf[$];
    logic [47:0] got_rng[$];
    logic [15:0] got_prim[$];
    logic [47:0] got_lr[$];
    int          got_done = 0;
    logic [9:0]  exp_addr[$];
    logic        exp_ovfq[$];
    logic [47:0] exp_rng[$];
    logic [15:0] exp_prim[$];
    logic [47:0] exp_lr[$];
    logic        exp_ovf;

    logic        test_next = 1'b0;
    logic [9:0]  test_addr = '0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_prim;
    logic [47:0] prev_lr;
    logic [71:0] cur_orig;
    logic [71:0] cur_inv;
    int          rdy_mode = 3;
    bit          junk_en = 1'b0;
    int          stall_cnt = 0;

    bvh_traverse_ctrl dut (
        .clk(clk), .rst(rst), .ray_valid(ray_valid), .ray_ready(ray_ready),
        .ray_orig_in(ray_orig_in), .ray_inv_dir_in(ray_inv_dir_in), .ray_range_in(ray_range_in),
        .node_rd_en(node_rd_en), .node_addr(node_addr), .node_data(node_data),
        .isect_orig(isect_orig), .isect_inv_dir(isect_inv_dir), .isect_box(isect_box),
        .isect_prev_range(isect_prev_range), .isect_hit(isect_hit), .isect_range(isect_range),
        .leaf_valid(leaf_valid), .leaf_ready(leaf_ready), .leaf_prim(leaf_prim),
        .leaf_range(leaf_range), .trav_done(trav_done), .stack_ovf(stack_ovf)
    );

    always #5 clk = ~clk;

    // One-cycle node memory; the intersector answer is whatever the table says for the node read.
    always @(posedge clk) begin
        if (node_rd_en) begin
            node_data <= {c1_tbl[node_addr], c0_tbl[node_addr], leaf_tbl[node_addr], box_tbl[node_addr]};
            rd_addr_q <= node_addr;
        end
    end
    assign isect_hit   = hit_tbl[rd_addr_q];
    assign isect_range = rng_tbl[rd_addr_q];

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] rand48();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[47:0];
    endfunction

    function automatic logic [71:0] rand72();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[71:0];
    endfunction

    function automatic logic [143:0] rand144();
        logic [159:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[143:0];
    endfunction

    task automatic set_node(input int a, input logic lf, input logic h,
                            input logic [9:0] c0, input logic [9:0] c1, input logic [47:0] r);
        box_tbl[a]  = rand144();
        leaf_tbl[a] = lf;
        hit_tbl[a]  = h;
        c0_tbl[a]   = c0;
        c1_tbl[a]   = c1;
        rng_tbl[a]  = r;
    endtask

    // Advance to the next falling edge, observe the DUT, then drive inputs for the coming rising edge.
    task automatic tick();
        @(negedge clk);
        if (!rst) begin
            if (test_next) begin
                check("isect_box", isect_box, box_tbl[test_addr]);
                check("isect_orig", isect_orig, cur_orig);
                check("isect_inv", isect_inv_dir, cur_inv);
                got_rng.push_back(isect_prev_range);
            end
            if (prev_stall) begin
                check("stall_valid", leaf_valid, 1'b1);
                check("stall_prim", leaf_prim, prev_prim);
                check("stall_range", leaf_range, prev_lr);
                check("stall_rd_en", node_rd_en, 1'b0);
            end
            if (node_rd_en) begin
                got_addr.push_back(node_addr);
                got_ovf.push_back(stack_ovf);
            end
            if (trav_done) got_done++;
        end
        test_next = !rst && node_rd_en;
        test_addr = node_addr;
        case (rdy_mode)
            0:       leaf_ready = 1'b1;
            1:       leaf_ready = ($urandom_range(0, 1) == 1);
            2:       leaf_ready = (stall_cnt >= 5);
            default: leaf_ready = 1'b0;
        endcase
        if (!rst && leaf_valid && !leaf_ready) stall_cnt++;
        if (!rst && leaf_valid && leaf_ready) begin
            got_prim.push_back(leaf_prim);
            got_lr.push_back(leaf_range);
        end
        prev_stall = !rst && leaf_valid && !leaf_ready;
        prev_prim  = leaf_prim;
        prev_lr    = leaf_range;
        ray_valid  = junk_en && !ray_ready && ($urandom_range(0, 1) == 1);
        if (ray_valid) begin
            ray_orig_in    = rand72();
            ray_inv_dir_in = rand72();
            ray_range_in   = rand48();
        end
    endtask

    task automatic accept_ray(input logic [47:0] r0);
        int k = 0;
        while (!ray_ready && k < 500) begin
            tick();
            k++;
        end
        check("accept_ready", ray_ready, 1'b1);
        cur_orig       = rand72();
        cur_inv        = rand72();
        ray_orig_in    = cur_orig;
        ray_inv_dir_in = cur_inv;
        ray_range_in   = r0;
        ray_valid      = 1'b1;
        tick();
    endtask

    // Depth-first walk straight from the node/hit tables.
    task automatic model(input logic [47:0] r0);
        ent_t        stk[$];
        ent_t        e;
        logic [9:0]  a;
        logic [47:0] r;
        logic        ovf;
        exp_addr.delete(); exp_ovfq.delete(); exp_rng.delete(); exp_prim.delete(); exp_lr.delete();
        a = '0;
        r = r0;
        ovf = 1'b0;
        for (int it = 0; it < 2000; it++) begin
            exp_addr.push_back(a);
            exp_rng.push_back(r);
            exp_ovfq.push_back(ovf);
            if (hit_tbl[a] && !leaf_tbl[a]) begin
                if (stk.size() == 16) ovf = 1'b1;
                else stk.push_back({c1_tbl[a], rng_tbl[a]});
                r = rng_tbl[a];
                a = c0_tbl[a];
            end else begin
                if (hit_tbl[a]) begin
                    exp_prim.push_back({6'd0, c0_tbl[a]});
                    exp_lr.push_back(rng_tbl[a]);
                end
                if (stk.size() == 0) break;
                e = stk.pop_back();
                a = e.a;
                r = e.r;
            end
        end
        exp_ovf = ovf;
    endtask

    task automatic run_ray(input int mode, input bit junk);
        int          b_addr = got_addr.size();
        int          b_rng  = got_rng.size();
        int          b_prim = got_prim.size();
        int          b_done = got_done;
        int          k = 0;
        logic [47:0] r0 = rand48();
        model(r0);
        rdy_mode  = mode;
        stall_cnt = 0;
        junk_en   = junk;
        accept_ray(r0);
        check("ovf_clear", stack_ovf, 1'b0);
        while (!trav_done && k < 4000) begin
            tick();
            k++;
        end
        check("done_seen", trav_done, 1'b1);
        check("ovf_final", stack_ovf, exp_ovf);
        junk_en = 1'b0;
        tick();
        check("ready_back", ray_ready, 1'b1);
        check("done_pulse", trav_done, 1'b0);
        check("done_count", got_done - b_done, 1);
        check("n_fetch", got_addr.size() - b_addr, exp_addr.size());
        for (int i = 0; i < exp_addr.size() && b_addr + i < got_addr.size(); i++) begin
            check("fetch_addr", got_addr[b_addr + i], exp_addr[i]);
            check("fetch_ovf", got_ovf[b_addr + i], exp_ovfq[i]);
            if (b_rng + i < got_rng.size()) check("fetch_range", got_rng[b_rng + i], exp_rng[i]);
        end
        check("n_leaf", got_prim.size() - b_prim, exp_prim.size());
        for (int i = 0; i < exp_prim.size() && b_prim + i < got_prim.size(); i++) begin
            check("leaf_prim", got_prim[b_prim + i], exp_prim[i]);
            check("leaf_range", got_lr[b_prim + i], exp_lr[i]);
        end
    endtask

    task automatic gen_tree();
        int         n = $urandom_range(3, 14);
        logic       lf;
        logic       h;
        logic [9:0] c0;
        logic [9:0] c1;
        for (int i = 0; i < n; i++) begin
            lf = (i == n - 1) || ($urandom_range(0, 3) == 0);
            h  = ($urandom_range(0, 9) < 8);
            if (lf) begin
                c0 = 10'($urandom_range(0, 1023));
                c1 = 10'($urandom_range(0, 1023));
            end else begin
                c0 = 10'($urandom_range(i + 1, n - 1));
                c1 = 10'($urandom_range(i + 1, n - 1));
            end
            set_node(i, lf, h, c0, c1, rand48());
        end
    endtask

    initial begin
        int          b;
        int          k;
        logic [47:0] r0v;
        for (int i = 0; i < 1024; i++) set_node(i, 1'b1, 1'b0, '0, '0, '0);
        rst = 1'b1;
        ray_valid = 1'b0;
        ray_orig_in = '0;
        ray_inv_dir_in = '0;
        ray_range_in = '0;
        leaf_ready = 1'b0;
        repeat (3) tick();
        check("rst_ready", ray_ready, 1'b1);
        check("rst_rd_en", node_rd_en, 1'b0);
        check("rst_addr", node_addr, 10'd0);
        check("rst_leaf_valid", leaf_valid, 1'b0);
        check("rst_done", trav_done, 1'b0);
        check("rst_ovf", stack_ovf, 1'b0);
        check("rst_prim", leaf_prim, 16'd0);
        check("rst_prev_range", isect_prev_range, 48'd0);
        rst = 1'b0;
        tick();

        // Root leaf: leaf_valid in the 3rd cycle after accept, done two cycles after the handshake.
        set_node(0, 1'b1, 1'b1, 10'd5, 10'd0, {24'h000100, 24'h000800});
        rdy_mode = 0;
        accept_ray(rand48());
        check("t1_rd_en", node_rd_en, 1'b1);
        check("t1_addr", node_addr, 10'd0);
        tick();
        check("t1_lv_c2", leaf_valid, 1'b0);
        tick();
        check("t1_lv_c3", leaf_valid, 1'b1);
        check("t1_prim", leaf_prim, 16'd5);
        check("t1_range", leaf_range, {24'h000100, 24'h000800});
        tick();
        check("t1_lv_c4", leaf_valid, 1'b0);
        check("t1_done_c4", trav_done, 1'b0);
        tick();
        check("t1_done_c5", trav_done, 1'b1);
        tick();
        check("t1_done_c6", trav_done, 1'b0);
        check("t1_ready_c6", ray_ready, 1'b1);

        // Root miss: FETCH, TEST, POP, DONE.
        set_node(0, 1'b1, 1'b0, 10'd5, 10'd0, rand48());
        b = got_prim.size();
        accept_ray(rand48());
        check("t2_rd_en", node_rd_en, 1'b1);
        tick();
        tick();
        check("t2_done_c3", trav_done, 1'b0);
        tick();
        check("t2_done_c4", trav_done, 1'b1);
        tick();
        check("t2_ready", ray_ready, 1'b1);
        check("t2_done_c5", trav_done, 1'b0);
        check("t2_no_leaf", got_prim.size() - b, 0);

        // Two-leaf tree, then the same tree with the first leaf stalled for 5 cycles.
        r0v = rand48();
        set_node(0, 1'b0, 1'b1, 10'd1, 10'd2, r0v);
        set_node(1, 1'b1, 1'b1, 10'd7, 10'd0, rand48());
        set_node(2, 1'b1, 1'b1, 10'd9, 10'd0, rand48());
        b = got_rng.size();
        run_ray(0, 1'b0);
        if (got_rng.size() >= b + 3) check("t3_pop_range", got_rng[b + 2], r0v);
        else check("t3_n_range", got_rng.size() - b, 3);
        run_ray(2, 1'b0);
        check("t4_stall_cnt", stall_cnt, 5);

        // Left spine 20 deep: far children miss, the 17th push overflows.
        for (int i = 0; i < 20; i++) begin
            set_node(i, 1'b0, 1'b1, 10'(i + 1), 10'(100 + i), rand48());
            set_node(100 + i, 1'b1, 1'b0, '0, '0, rand48());
        end
        set_node(20, 1'b1, 1'b1, 10'd3, 10'd0, rand48());
        b = got_ovf.size();
        run_ray(0, 1'b0);
        if (got_ovf.size() >= b + 18) begin
            check("t5_ovf_n16", got_ovf[b + 16], 1'b0);
            check("t5_ovf_n17", got_ovf[b + 17], 1'b1);
        end else begin
            check("t5_n_fetch", got_ovf.size() - b, 37);
        end
        check("t5_ovf_held", stack_ovf, 1'b1);
        run_ray(1, 1'b0);

        // Reset while a leaf is pending.
        set_node(0, 1'b1, 1'b1, 10'd5, 10'd0, rand48());
        rdy_mode = 3;
        b = got_done;
        accept_ray(rand48());
        k = 0;
        while (!leaf_valid && k < 20) begin
            tick();
            k++;
        end
        check("t6_leaf_pending", leaf_valid, 1'b1);
        rst = 1'b1;
        tick();
        check("t6_lv", leaf_valid, 1'b0);
        check("t6_ready", ray_ready, 1'b1);
        check("t6_rd_en", node_rd_en, 1'b0);
        check("t6_done", trav_done, 1'b0);
        rst = 1'b0;
        rdy_mode = 0;
        repeat (3) begin
            tick();
            check("t6_idle_done", trav_done, 1'b0);
            check("t6_idle_ready", ray_ready, 1'b1);
        end
        check("t6_no_done", got_done - b, 0);

        // Random trees, random downstream backpressure, junk ray_valid during traversal.
        repeat (30) begin
            for (int t = 0; t < 20; t++) begin
                gen_tree();
                model(48'd0);
                if (exp_addr.size() <= 300) break;
            end
            run_ray(1, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
